// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and digit limits for the MM:SS.t stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int TENTHS_MAX   = 9;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;
  localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Control pulses in, BCD display digits and status out.
interface stopwatch_bcd_if;
  logic       enable;
  logic       HundredmsTimeout;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       running;
  logic       lap_active;
  logic       wrap;

  modport master (
    output enable, HundredmsTimeout, start_stop, clear, lap,
    input  tenths, sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
  );

  modport slave (
    input  enable, HundredmsTimeout, start_stop, clear, lap,
    output tenths, sec_ones, sec_tens, min_ones, min_tens, running, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit: counts 0..MAX on inc, clr wins, carry is combinational.
module bcd_digit_cnt #(
  parameter int MAX   = 9,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] digit,
  output logic             carry
);

  logic [WIDTH-1:0] r_digit;
  logic             w_at_max;

  assign w_at_max = (r_digit == WIDTH'(MAX));

  always_ff @(posedge clk) begin
    if (!rst)
      r_digit <= '0;
    else if (clr)
      r_digit <= '0;
    else if (inc)
      r_digit <= w_at_max ? '0 : r_digit + WIDTH'(1);
  end

  assign digit = r_digit;
  assign carry = inc && w_at_max;

endmodule

// File: rtl/stopwatch_bcd.sv
// Start/stop/clear stopwatch over a five-digit BCD carry chain.
// Optional lap-hold display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd
  import stopwatch_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  stopwatch_bcd_if.slave sw
);

  state_t      r_state, w_state_next;
  logic        r_running, r_wrap;
  logic        w_tick, w_clr;
  logic [4:0]  w_carry;
  logic [3:0]  w_tenths, w_sec_ones, w_min_ones;
  logic [2:0]  w_sec_tens, w_min_tens;
  logic [17:0] w_live, w_disp;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // clear beats start_stop outside RUN; inside RUN only start_stop matters
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (sw.clear) w_clr = 1'b1;
        else if (sw.start_stop) w_state_next = RUN;
      end
      RUN: begin
        if (sw.start_stop) w_state_next = PAUSED;
      end
      PAUSED: begin
        if (sw.clear) begin
          w_clr        = 1'b1;
          w_state_next = IDLE;
        end else if (sw.start_stop) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tick = (r_state == RUN) && sw.enable && sw.HundredmsTimeout;

  bcd_digit_cnt #(.MAX(TENTHS_MAX),   .WIDTH(4)) u_tenths (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_tick),     .digit(w_tenths),   .carry(w_carry[0]));
  bcd_digit_cnt #(.MAX(SEC_ONES_MAX), .WIDTH(4)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_carry[0]), .digit(w_sec_ones), .carry(w_carry[1]));
  bcd_digit_cnt #(.MAX(SEC_TENS_MAX), .WIDTH(3)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_carry[1]), .digit(w_sec_tens), .carry(w_carry[2]));
  bcd_digit_cnt #(.MAX(MIN_ONES_MAX), .WIDTH(4)) u_min_ones (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_carry[2]), .digit(w_min_ones), .carry(w_carry[3]));
  bcd_digit_cnt #(.MAX(MIN_TENS_MAX), .WIDTH(3)) u_min_tens (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_carry[3]), .digit(w_min_tens), .carry(w_carry[4]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_running <= (w_state_next == RUN);
      r_wrap    <= w_carry[4];
    end
  end

  assign w_live = {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones, w_tenths};

`ifdef STOPWATCH_LAP_EN
  logic        r_lap_active;
  logic [17:0] r_hold;

  // the hold register samples the count before this edge's increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lap_active <= 1'b0;
      r_hold       <= '0;
    end else if (w_state_next == IDLE) begin
      r_lap_active <= 1'b0;
    end else if (sw.lap && r_lap_active && (r_state == RUN || r_state == PAUSED)) begin
      r_lap_active <= 1'b0;
    end else if (sw.lap && !r_lap_active && r_state == RUN) begin
      r_lap_active <= 1'b1;
      r_hold       <= w_live;
    end
  end

  assign w_disp        = r_lap_active ? r_hold : w_live;
  assign sw.lap_active = r_lap_active;
`else
  logic w_unused_lap;
  assign w_unused_lap  = sw.lap;
  assign w_disp        = w_live;
  assign sw.lap_active = 1'b0;
`endif

  assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.tenths} = w_disp;
  assign sw.running = r_running;
  assign sw.wrap    = r_wrap;

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Tenths-resolution stopwatch that consumes the one-cycle 100 ms timeout pulse from the tenth-second prescaler and keeps an MM:SS.t count in BCD for the seven-segment display driver. A start/stop/clear state machine controls counting, driven by debounced single-cycle button pulses. An optional lap-hold feature freezes the displayed value while counting continues internally.

## Interface
Parameters:
- none; digit limits are fixed constants in the shared package.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- enable  in  1  tick gate; when low, tick pulses are ignored and button pulses are still processed.
- HundredmsTimeout  in  1  one-cycle tick, one per 100 ms.
- start_stop  in  1  one-cycle debounced button pulse.
- clear  in  1  one-cycle debounced button pulse.
- lap  in  1  one-cycle debounced button pulse; ignored unless LAP_EN is defined.
- tenths  out  4  displayed tenths digit, 0–9.
- sec_ones  out  4  displayed seconds ones digit, 0–9.
- sec_tens  out  3  displayed seconds tens digit, 0–5.
- min_ones  out  4  displayed minutes ones digit, 0–9.
- min_tens  out  3  displayed minutes tens digit, 0–5.
- running  out  1  high while in state RUN.
- lap_active  out  1  high while the display is frozen.
- wrap  out  1  one-cycle pulse when the count rolls over from 59:59.9 to 00:00.0.

## Operation
- States:
  - IDLE: count is zero.
  - RUN: ticks are counted.
  - PAUSED: count is held.
- Transitions, evaluated on the current state:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSED.
  - PAUSED + start_stop → RUN.
  - IDLE or PAUSED + clear → IDLE, and all digits are zeroed.
  - In RUN, clear is ignored.
- Simultaneous start_stop and clear:
  - In PAUSED or IDLE, clear wins and the next state is IDLE.
  - In RUN, start_stop wins and the next state is PAUSED.
- Counting: the count increments by 0.1 s only when the current state is RUN, enable=1 and HundredmsTimeout=1.
  - A tick arriving in the same cycle as start_stop from RUN is counted.
  - A tick arriving in the same cycle as the IDLE→RUN transition is not counted.
- Carry chain:
  - tenths wraps 9→0 and carries to sec_ones.
  - sec_ones wraps 9→0 and carries to sec_tens.
  - sec_tens wraps 5→0 and carries to min_ones.
  - min_ones wraps 9→0 and carries to min_tens.
  - min_tens wraps 5→0.
- Rollover: at 59:59.9, a tick gives 00:00.0, wrap=1 for one cycle, and the state stays RUN.
- Digits never hold illegal BCD values.

## Timing
- Reset values: state IDLE, all digits 0, running=0, lap_active=0, wrap=0.
- All outputs are registered.
- A tick sampled at edge N appears on the digits after edge N; wrap is high for the cycle following that edge.
- running follows the state register with one-edge latency after the button pulse.
- Reset asserted mid-count returns every output to its reset value on the next edge, regardless of state or pending pulses.
- Back-to-back ticks on consecutive cycles are each counted; no tick is lost.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - A lap pulse in RUN with lap_active=0 sets lap_active=1. The display outputs then capture the count value present before that edge's update and stay frozen while the internal count keeps advancing.
  - A lap pulse in RUN or PAUSED with lap_active=1 clears lap_active; the display then tracks the live count from the next edge.
  - A transition to IDLE clears lap_active.
  - wrap still follows the internal count.
- Not defined:
  - The lap input is ignored.
  - lap_active is tied to 0.
  - The display outputs are the live count registers.

## Structure
- Package `stopwatch_pkg` contains:
  - the state enum typedef (IDLE, RUN, PAUSED);
  - the constants TENTHS_MAX=9, SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5.
- Sub-module `bcd_digit_cnt`, instantiated five times in a carry chain:
  - parameters MAX and WIDTH;
  - inputs clk, rst, clr, inc;
  - outputs digit, and carry (combinational: inc && digit==MAX).

## Test plan
- Reset, start_stop, then 25 ticks → display reads 00:02.5; running=1; wrap never asserted.
- In RUN: start_stop, then 5 ticks → count frozen at 00:02.5. clear then zeroes all digits, and the state is IDLE.
- Preload via ticks to 59:59.9, then one tick → 00:00.0, wrap high for exactly one cycle, running stays 1.
- start_stop and clear in the same cycle:
  - from RUN → PAUSED with count kept;
  - from PAUSED → IDLE with zero count.
- enable=0 during 10 ticks in RUN → count unchanged; start_stop still moves the state to PAUSED.
- With STOPWATCH_LAP_EN, lap at 00:01.0 followed by 20 ticks → display holds 00:01.0 while lap_active=1. A second lap → display shows 00:03.0.
